chip_top_lite: RTL and testbench

- Minimal chip-level top used as the simulation target of the SoC bench: a clock/reset front end, an 8N1 UART with a boot banner, and an LED/DIP status block.
- After reset it sends a fixed ASCII banner on txd, then idles.
- Drives board status LEDs and mirrors DIP switches.
- With the optional feature it echoes received UART bytes back on txd.

---
 rtl/chip_top_lite_if.sv | 6 +
 rtl/chip_top_lite.sv | 138 +++++++++++++
 tb/tb_chip_top_lite.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip_top_lite_if.sv
// chip_top_lite_if: UART pin bundle, rxd/txd data lines plus cts/rts flow control
interface chip_top_lite_if;
  logic rxd, txd, cts, rts;
  modport master (output rxd, cts, input txd, rts);
  modport slave (input rxd, cts, output txd, rts);
endinterface

// File: rtl/chip_top_lite.sv
// chip_top_lite: chip top with boot-banner 8N1 UART, cts/rts flow control and LED/DIP status
// Ports: clk_p rising-edge clock (clk_n its unused complement), rst_top sync active-high reset,
//   uart (chip_top_lite_if.slave: rxd in, txd out, cts in, rts out), i_dip[15:0] switches, o_led[7:0] status.
// Optional: define UART_ECHO_EN to hold received bytes and echo them on txd after the banner.
module chip_top_lite #(
  parameter int CLK_DIV = 52,
  parameter int BOOT_DELAY = 16
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst_top,
  chip_top_lite_if.slave uart,
  input  logic [15:0] i_dip,
  output logic [7:0] o_led
);
  localparam logic [71:0] BANNER = 72'h6C_6F_77_52_49_53_43_0D_0A;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BOOT_CNT = 16'(BOOT_DELAY);
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_STOP} tx_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  tx_t r_tx, w_tx_nx;
  rx_t r_rx, w_rx_nx;
  logic [15:0] r_div, r_rdiv, r_boot;
  logic [2:0] r_bit, r_rbit;
  logic [3:0] r_bidx;
  logic [7:0] r_tx_byte, r_rx_byte, r_led, w_hold, w_ban_byte;
  logic [6:0] w_boff;
  logic r_s1, r_s2, r_prev, r_banner_done, r_err;
  logic w_div_end, w_rdiv_end, w_half_end, w_ban_pend, w_echo_pend, w_have, w_load, w_take;
  logic w_fall, w_rx_ok, w_rx_err, w_overrun, w_hold_v, w_busy, w_txd, w_unused;
  assign w_unused = ^{clk_n, i_dip[15:5], w_rx_ok, r_rx_byte};
  assign w_div_end = r_div == DIV_LAST;
  assign w_ban_pend = (r_boot == BOOT_CNT) && (r_bidx != 4'd9);
  assign w_echo_pend = r_banner_done & w_hold_v;
  assign w_have = w_ban_pend | w_echo_pend;
  assign w_load = (w_tx_nx == T_START) && (r_tx != T_START);
  assign w_take = w_load & ~w_ban_pend;
  // Banner byte 0 sits in the top byte of BANNER
  assign w_boff = {4'd8 - r_bidx, 3'b000};
  assign w_ban_byte = 8'(BANNER >> w_boff);
  always_ff @(posedge clk_p)
    if (rst_top) r_tx <= T_IDLE;
    else r_tx <= w_tx_nx;
  // cts is only looked at on the way into a start bit
  always_comb begin
    w_tx_nx = r_tx;
    case (r_tx)
      T_IDLE: w_tx_nx = w_have ? (uart.cts ? T_START : T_WAIT) : T_IDLE;
      T_WAIT: w_tx_nx = uart.cts ? T_START : T_WAIT;
      T_START: w_tx_nx = w_div_end ? T_DATA : T_START;
      T_DATA: w_tx_nx = (w_div_end && r_bit == 3'd7) ? T_STOP : T_DATA;
      T_STOP: w_tx_nx = !w_div_end ? T_STOP : !w_have ? T_IDLE : uart.cts ? T_START : T_WAIT;
      default: w_tx_nx = T_IDLE;
    endcase
  end
  always_comb begin
    w_busy = r_tx inside {T_START, T_DATA, T_STOP};
    w_txd = (r_tx == T_START) ? 1'b0 : (r_tx == T_DATA) ? r_tx_byte[r_bit] : 1'b1;
  end
  always_ff @(posedge clk_p)
    if (rst_top) begin
      r_div <= 16'd0;
      r_bit <= 3'd0;
      r_boot <= 16'd0;
      r_bidx <= 4'd0;
      r_tx_byte <= 8'h00;
      r_banner_done <= 1'b0;
    end else begin
      r_div <= (r_tx == T_IDLE || r_tx == T_WAIT || w_div_end) ? 16'd0 : r_div + 16'd1;
      r_bit <= (r_tx == T_DATA) ? r_bit + {2'b00, w_div_end} : 3'd0;
      if (r_boot != BOOT_CNT) r_boot <= r_boot + 16'd1;
      if (w_load) r_tx_byte <= w_ban_pend ? w_ban_byte : w_hold;
      if (w_load && w_ban_pend) r_bidx <= r_bidx + 4'd1;
      if (r_tx == T_STOP && w_div_end && r_bidx == 4'd9) r_banner_done <= 1'b1;
    end
  always_ff @(posedge clk_p)
    if (rst_top) {r_s1, r_s2, r_prev} <= 3'b111;
    else {r_s1, r_s2, r_prev} <= {uart.rxd, r_s1, r_s2};
  assign w_fall = r_prev & ~r_s2;
  assign w_half_end = (r_rx == R_START) && (r_rdiv == HALF_LAST);
  assign w_rdiv_end = r_rdiv == DIV_LAST;
  always_ff @(posedge clk_p)
    if (rst_top) r_rx <= R_IDLE;
    else r_rx <= w_rx_nx;
  // A line back high at mid start bit is a false start, not an error
  always_comb begin
    w_rx_nx = r_rx;
    case (r_rx)
      R_IDLE: w_rx_nx = w_fall ? R_START : R_IDLE;
      R_START: w_rx_nx = !w_half_end ? R_START : r_s2 ? R_IDLE : R_DATA;
      R_DATA: w_rx_nx = (w_rdiv_end && r_rbit == 3'd7) ? R_STOP : R_DATA;
      R_STOP: w_rx_nx = w_rdiv_end ? R_IDLE : R_STOP;
      default: w_rx_nx = R_IDLE;
    endcase
  end
  always_comb begin
    w_rx_ok = (r_rx == R_STOP) & w_rdiv_end & r_s2;
    w_rx_err = (r_rx == R_STOP) & w_rdiv_end & ~r_s2;
  end
  always_ff @(posedge clk_p)
    if (rst_top) begin
      r_rdiv <= 16'd0;
      r_rbit <= 3'd0;
      r_rx_byte <= 8'h00;
      r_err <= 1'b0;
      r_led <= 8'h00;
    end else begin
      r_rdiv <= (r_rx == R_IDLE || w_half_end || w_rdiv_end) ? 16'd0 : r_rdiv + 16'd1;
      r_rbit <= (r_rx == R_DATA) ? r_rbit + {2'b00, w_rdiv_end} : 3'd0;
      if (r_rx == R_DATA && w_rdiv_end) r_rx_byte <= {r_s2, r_rx_byte[7:1]};
      r_err <= r_err | w_rx_err | w_overrun;
      r_led <= {i_dip[4:0], w_busy, r_err, r_banner_done};
    end
`ifdef UART_ECHO_EN
  logic r_hold_v;
  logic [7:0] r_hold;
  // A byte arriving in the same cycle the old one leaves for TX still fits
  always_ff @(posedge clk_p)
    if (rst_top) begin
      r_hold_v <= 1'b0;
      r_hold <= 8'h00;
    end else begin
      if (w_rx_ok && (!r_hold_v || w_take)) r_hold <= r_rx_byte;
      r_hold_v <= w_rx_ok | (r_hold_v & ~w_take);
    end
  assign w_hold_v = r_hold_v;
  assign w_hold = r_hold;
  assign w_overrun = w_rx_ok & r_hold_v & ~w_take;
`else
  assign w_hold_v = 1'b0;
  assign w_hold = 8'h00;
  assign w_overrun = 1'b0;
`endif
  assign uart.txd = w_txd;
  assign uart.rts = ~rst_top & ~w_hold_v;
  assign o_led = r_led;
endmodule

// File: tb/tb_chip_top_lite.sv
// tb_chip_top_lite: scoreboard bench decoding txd frames against queued expected bytes
module tb_chip_top_lite;
  localparam int CLK_DIV = 52;
  localparam int BOOT = 16;
  localparam int FRAME = 10 * CLK_DIV;
  logic clk_p = 1'b0;
  logic clk_n;
  logic rst_top = 1'b1;
  logic [15:0] i_dip = 16'h0000;
  logic [7:0] o_led;
  chip_top_lite_if u();
  chip_top_lite #(.CLK_DIV(CLK_DIV), .BOOT_DELAY(BOOT)) dut (
    .clk_p(clk_p), .clk_n(clk_n), .rst_top(rst_top), .uart(u.slave), .i_dip(i_dip), .o_led(o_led)
  );
  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rts_lo = 0;
  int starts[$];
  logic [7:0] exp_q[$];
  bit mon_en = 1'b1;
  logic [7:0] banner[9] = '{8'h6C, 8'h6F, 8'h77, 8'h52, 8'h49, 8'h53, 8'h43, 8'h0D, 8'h0A};
  always @(posedge clk_p) cyc <= cyc + 1;
  always @(negedge clk_p) if (!rst_top && u.rts !== 1'b1) rts_lo++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic at_pos(input int c);
    while (cyc < c) begin @(posedge clk_p); #1; end
  endtask
  task automatic to_neg(input int c);
    while (cyc < c) @(negedge clk_p);
  endtask
  task automatic push_banner();
    for (int i = 0; i < 9; i++) exp_q.push_back(banner[i]);
  endtask
  task automatic wait_q(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk_p); n++; end
    check("queue_drain", exp_q.size(), 0);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_p); #1 u.rxd = f[i];
      repeat (CLK_DIV - 1) @(posedge clk_p);
    end
    @(posedge clk_p); #1 u.rxd = 1'b1;
  endtask
  logic [7:0] m_b, m_e;
  logic m_sb, m_eb;
  initial forever begin
    @(negedge clk_p);
    if (u.txd === 1'b0) begin
      starts.push_back(cyc);
      repeat (CLK_DIV / 2) @(negedge clk_p);
      m_sb = u.txd;
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk_p);
        m_b[i] = u.txd;
      end
      repeat (CLK_DIV) @(negedge clk_p);
      m_eb = u.txd;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %02h expected none", m_b);
        end else begin
          m_e = exp_q.pop_front();
          if ({m_sb, m_b, m_eb} !== {1'b0, m_e, 1'b1}) begin
            errors++;
            $display("FAIL tx_byte: got start %b data %02h stop %b expected 0 %02h 1", m_sb, m_b, m_eb, m_e);
          end
        end
      end
    end
  end
  int rel, x, y, lo0, busy_zero, done_early, gap_bad;
  initial begin
    u.rxd = 1'b1;
    u.cts = 1'b1;
    repeat (12) @(posedge clk_p);
    @(negedge clk_p);
    check("rst_txd", u.txd, 1);
    check("rst_rts", u.rts, 0);
    check("rst_led", o_led, 8'h00);
    @(posedge clk_p); #1 rst_top = 1'b0;
    rel = cyc;
    starts.delete();
    push_banner();
    @(negedge clk_p);
    check("rts_run", u.rts, 1);
    to_neg(rel + 18);
    busy_zero = 0;
    done_early = 0;
    for (int i = 0; i < 9 * FRAME; i++) begin
      if (o_led[2] !== 1'b1) busy_zero++;
      if (o_led[0] !== 1'b0) done_early++;
      @(negedge clk_p);
    end
    check("busy_gaps", busy_zero, 0);
    check("done_early", done_early, 0);
    check("banner_done_led", o_led[2:0], 3'b001);
    check("first_start", starts.size() > 0 ? starts[0] : -1, rel + BOOT + 1);
    check("frame_count", starts.size(), 9);
    gap_bad = 0;
    for (int k = 1; k < starts.size(); k++) if (starts[k] - starts[k-1] != FRAME) gap_bad++;
    check("frame_gaps", gap_bad, 0);
    check("banner_all", exp_q.size(), 0);
    @(posedge clk_p); #1 i_dip = 16'h0015;
    @(negedge clk_p);
    check("dip_latency", o_led, 8'h01);
    @(negedge clk_p);
    check("dip_15", o_led, 8'hA9);
    @(posedge clk_p); #1 i_dip = 16'hFFF5;
    @(negedge clk_p); @(negedge clk_p);
    check("dip_upper_ignored", o_led, 8'hA9);
    @(posedge clk_p); #1 i_dip = 16'h000A;
    @(negedge clk_p); @(negedge clk_p);
    check("dip_0a", o_led, 8'h51);
    @(posedge clk_p); #1 u.rxd = 1'b0;
    repeat (10) @(posedge clk_p);
    #1 u.rxd = 1'b1;
    repeat (100) @(posedge clk_p);
    @(negedge clk_p);
    check("glitch_no_err", o_led[1], 0);
    lo0 = rts_lo;
`ifdef UART_ECHO_EN
    exp_q.push_back(8'h3C);
`endif
    send_rx(8'h3C, 1'b1);
    repeat (FRAME + 100) @(posedge clk_p);
    @(negedge clk_p);
    check("good_no_err", o_led[1], 0);
    check("good_drained", exp_q.size(), 0);
`ifdef UART_ECHO_EN
    check("rts_dropped", rts_lo > lo0, 1);
`else
    check("rts_steady", rts_lo - lo0, 0);
`endif
    check("rts_after_good", u.rts, 1);
    send_rx(8'h5A, 1'b0);
    repeat (20) @(posedge clk_p);
    @(negedge clk_p);
    check("frame_err", o_led[1], 1);
    repeat (FRAME) @(posedge clk_p);
    @(negedge clk_p);
    check("frame_err_sticky", o_led[1], 1);
    u.cts = 1'b0;
    rst_top = 1'b1;
    repeat (13) @(posedge clk_p);
    @(negedge clk_p);
    check("rst2_led", o_led, 8'h00);
    @(posedge clk_p); #1 rst_top = 1'b0;
    rel = cyc;
    starts.delete();
    exp_q.delete();
    push_banner();
    to_neg(rel + 2);
    check("rst2_led_run", o_led, 8'h50);
    at_pos(rel + 2000);
    check("cts_wait_nostart", starts.size(), 0);
    check("cts_wait_txd", u.txd, 1);
    u.cts = 1'b1;
    x = cyc;
    at_pos(x + 1 + 2 * FRAME + FRAME / 2);
    u.cts = 1'b0;
    to_neg(x + 1 + 3 * FRAME + 300);
    check("cts_hold_starts", starts.size(), 3);
    check("cts_hold_txd", u.txd, 1);
    @(posedge clk_p); #1 u.cts = 1'b1;
    y = cyc;
    to_neg(y + 2);
    check("cts_first_start", starts.size() > 0 ? starts[0] : -1, x + 1);
    check("cts_resume_start", starts.size() > 3 ? starts[3] : -1, y + 1);
    wait_q(7 * FRAME);
    repeat (100) @(posedge clk_p);
    @(negedge clk_p);
    check("banner2_done", o_led[0], 1);
`ifdef UART_ECHO_EN
    @(posedge clk_p); #1 u.cts = 1'b0;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (20) @(posedge clk_p);
    @(negedge clk_p);
    check("overrun_err", o_led[1], 1);
    check("rts_full", u.rts, 0);
    check("no_echo_cts0", starts.size(), 9);
    exp_q.push_back(8'h11);
    @(posedge clk_p); #1 u.cts = 1'b1;
    wait_q(FRAME + 100);
    repeat (2 * FRAME) @(posedge clk_p);
    @(negedge clk_p);
    check("rts_free", u.rts, 1);
    check("echo_once", starts.size(), 10);
`endif
    rst_top = 1'b1;
    repeat (3) @(posedge clk_p);
    #1 rst_top = 1'b0;
    rel = cyc;
    mon_en = 1'b0;
    exp_q.delete();
    at_pos(rel + BOOT + 4);
    @(negedge clk_p);
    check("abort_pre_txd", u.txd, 0);
    @(posedge clk_p); #1 rst_top = 1'b1;
    @(posedge clk_p);
    @(negedge clk_p);
    check("abort_txd", u.txd, 1);
    check("abort_rts", u.rts, 0);
    check("abort_led", o_led, 8'h00);
    repeat (FRAME + 50) @(posedge clk_p);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
